fp_job_sequencer: RTL and testbench

Parametrised RAM-to-FP-unit job sequencer. On `start` it reads `N_OPS` operand pairs as big-endian bytes from a byte-wide synchronous RAM and issues each pair to an external floating-point unit over a start/done handshake. It writes each 32-bit result back to RAM as big-endian bytes and then reports `done`. A per-operation watchdog detects a stalled FP unit. This block is the generalised successor of the fixed 2-operand, free-running RAM/float sequencer.

---
 rtl/fp_seq_pkg.sv | 17 +
 rtl/fp_job_sequencer_wait_timer.sv | 30 +++
 rtl/fp_job_sequencer.sv | 143 ++++++++++++++
 tb/tb_fp_job_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// rtl/fp_seq_pkg.sv - shared state encoding and constants for the FP job sequencer
package fp_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      ISSUE,
      WAIT,
      WRITE,
      DONE
   } state_t;

   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam int          OPND_BYTES = 8;
   localparam int          RES_BYTES  = 4;

endpackage

// File: rtl/fp_job_sequencer_wait_timer.sv
// rtl/fp_job_sequencer_wait_timer.sv - per-operation FP unit watchdog down-counter
module fp_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Loaded with TIMEOUT-1 so the flag rises in the TIMEOUT-th WAIT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= LOAD_VAL;
      end else if (enable && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/fp_job_sequencer.sv
// rtl/fp_job_sequencer.sv - RAM-to-FP-unit job sequencer with per-op watchdog
module fp_job_sequencer
   import fp_seq_pkg::*;
#(
   parameter int                ADDR_W   = 8,
   parameter int                N_OPS    = 2,
   parameter logic [ADDR_W-1:0] SRC_BASE = 8'h00,
   parameter logic [ADDR_W-1:0] DST_BASE = 8'h40,
   parameter int                TIMEOUT  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] addr,
   input  logic [7:0]        rdata,
   output logic [7:0]        wdata,
   output logic              wen,
   output logic [31:0]       fp_a,
   output logic [31:0]       fp_b,
   output logic              fp_start,
   input  logic [31:0]       fp_result,
   input  logic              fp_done
);

   localparam int KW = 5;

   state_t            state;
   logic [3:0]        step;
   logic [KW-1:0]     k;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [31:0]       result;
   logic [31:0]       wait_res;
   logic              expired;

   fp_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state == ISSUE),
      .enable  (state == WAIT),
      .expired (expired)
   );

   // A real completion takes priority over a watchdog expiry in the same cycle.
   assign wait_res = fp_done ? fp_result : FP_QNAN;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         step     <= '0;
         k        <= '0;
         src_ptr  <= SRC_BASE;
         dst_ptr  <= DST_BASE;
         result   <= '0;
         addr     <= '0;
         wdata    <= '0;
         wen      <= 1'b0;
         fp_a     <= '0;
         fp_b     <= '0;
         fp_start <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         wen      <= 1'b0;
         fp_start <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= READ;
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  k       <= '0;
                  step    <= '0;
                  src_ptr <= SRC_BASE;
                  dst_ptr <= DST_BASE;
                  addr    <= SRC_BASE;
               end
            end
            READ: begin
               // rdata lags addr by one cycle, so step s captures byte s-1.
               if (step != 4'd0) begin
                  if (step <= 4'(RES_BYTES)) fp_a <= {fp_a[23:0], rdata};
                  else                       fp_b <= {fp_b[23:0], rdata};
               end
               if (step < 4'(OPND_BYTES - 1)) addr <= addr + ADDR_W'(1);
               if (step == 4'(OPND_BYTES)) begin
                  step     <= '0;
                  state    <= ISSUE;
                  fp_start <= 1'b1;
               end else begin
                  step <= step + 4'd1;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (fp_done || expired) begin
                  if (!fp_done) err <= 1'b1;
                  result <= wait_res;
                  wdata  <= wait_res[31:24];
                  wen    <= 1'b1;
                  addr   <= dst_ptr;
                  step   <= '0;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               if (step == 4'(RES_BYTES - 1)) begin
                  step    <= '0;
                  dst_ptr <= dst_ptr + ADDR_W'(RES_BYTES);
                  if (k == KW'(N_OPS - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     k       <= k + KW'(1);
                     src_ptr <= src_ptr + ADDR_W'(OPND_BYTES);
                     addr    <= src_ptr + ADDR_W'(OPND_BYTES);
                     state   <= READ;
                  end
               end else begin
                  step   <= step + 4'd1;
                  wen    <= 1'b1;
                  addr   <= addr + ADDR_W'(1);
                  wdata  <= result[23:16];
                  result <= {result[23:0], 8'h00};
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_job_sequencer.sv
// tb/tb_fp_job_sequencer.sv - scoreboard bench for fp_job_sequencer
module tb_fp_job_sequencer;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_start = 1'b0, a_busy, a_done, a_err, a_wen, a_fp_start;
   logic [7:0]  a_addr, a_rdata, a_wdata;
   logic [31:0] a_fp_a, a_fp_b, a_fp_result = '0;
   logic        a_fp_done = 1'b0;
   logic        b_start = 1'b0, b_busy, b_done, b_err, b_wen, b_fp_start;
   logic [7:0]  b_addr, b_rdata, b_wdata;
   logic [31:0] b_fp_a, b_fp_b, b_fp_result = '0;
   logic        b_fp_done = 1'b0;

   fp_job_sequencer #(.ADDR_W(8), .N_OPS(2), .SRC_BASE(8'h00), .DST_BASE(8'h40), .TIMEOUT(64)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
      .addr(a_addr), .rdata(a_rdata), .wdata(a_wdata), .wen(a_wen), .fp_a(a_fp_a), .fp_b(a_fp_b),
      .fp_start(a_fp_start), .fp_result(a_fp_result), .fp_done(a_fp_done));

   fp_job_sequencer #(.ADDR_W(8), .N_OPS(1), .SRC_BASE(8'hFC), .DST_BASE(8'h40), .TIMEOUT(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
      .addr(b_addr), .rdata(b_rdata), .wdata(b_wdata), .wen(b_wen), .fp_a(b_fp_a), .fp_b(b_fp_b),
      .fp_start(b_fp_start), .fp_result(b_fp_result), .fp_done(b_fp_done));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Operand memories are preloaded by the bench; DUT writes go to the scoreboard.
   logic [7:0] ram_a [0:255];
   logic [7:0] ram_b [0:255];
   always @(posedge clk) begin
      a_rdata <= ram_a[a_addr];
      b_rdata <= ram_b[b_addr];
   end

   logic [63:0] a_opq[$], b_opq[$];
   logic [31:0] a_resq[$], b_resq[$];
   int          a_latq[$], b_latq[$];
   logic [15:0] a_wq[$], b_wq[$];
   int          a_cnt = 0, b_cnt = 0, a_dones = 0, b_dones = 0;
   logic [31:0] a_pend, b_pend;
   logic [63:0] a_op, b_op;
   logic [15:0] a_w, b_w;

   task automatic push_op(input bit sel, input logic [7:0] src, input logic [7:0] dst,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic [31:0] wres, input int lat, input int nwr);
      logic [63:0] ab;
      logic [7:0]  ad;
      ab = {a, b};
      for (int i = 0; i < 8; i++) begin
         ad = src + 8'(i);
         if (sel) ram_b[ad] = ab[63-8*i -: 8];
         else     ram_a[ad] = ab[63-8*i -: 8];
      end
      for (int j = 0; j < nwr; j++) begin
         if (sel) b_wq.push_back({dst + 8'(j), wres[31-8*j -: 8]});
         else     a_wq.push_back({dst + 8'(j), wres[31-8*j -: 8]});
      end
      if (sel) begin b_opq.push_back(ab); b_resq.push_back(r); b_latq.push_back(lat); end
      else     begin a_opq.push_back(ab); a_resq.push_back(r); a_latq.push_back(lat); end
   endtask

   // FP unit models (lat 0 = never answers) and write-back scoreboards.
   always @(negedge clk) begin
      a_fp_done = 1'b0;
      if (a_cnt > 0) begin
         a_cnt--;
         if (a_cnt == 0) begin a_fp_done = 1'b1; a_fp_result = a_pend; end
      end
      if (a_fp_start) begin
         if (a_opq.size() == 0) chk("a_unexpected_issue", 1, 0);
         else begin
            a_op = a_opq.pop_front();
            chk("a_fp_a", a_fp_a, a_op[63:32]);
            chk("a_fp_b", a_fp_b, a_op[31:0]);
            a_cnt  = a_latq.pop_front();
            a_pend = a_resq.pop_front();
         end
      end
      if (a_wen) begin
         if (a_wq.size() == 0) chk("a_unexpected_write", {24'h0, a_addr}, 32'hFFFF_FFFF);
         else begin
            a_w = a_wq.pop_front();
            chk("a_wr_addr", {24'h0, a_addr}, {24'h0, a_w[15:8]});
            chk("a_wr_data", {24'h0, a_wdata}, {24'h0, a_w[7:0]});
         end
      end
      if (a_done) a_dones++;
   end

   always @(negedge clk) begin
      b_fp_done = 1'b0;
      if (b_cnt > 0) begin
         b_cnt--;
         if (b_cnt == 0) begin b_fp_done = 1'b1; b_fp_result = b_pend; end
      end
      if (b_fp_start) begin
         if (b_opq.size() == 0) chk("b_unexpected_issue", 1, 0);
         else begin
            b_op = b_opq.pop_front();
            chk("b_fp_a", b_fp_a, b_op[63:32]);
            chk("b_fp_b", b_fp_b, b_op[31:0]);
            b_cnt  = b_latq.pop_front();
            b_pend = b_resq.pop_front();
         end
      end
      if (b_wen) begin
         if (b_wq.size() == 0) chk("b_unexpected_write", {24'h0, b_addr}, 32'hFFFF_FFFF);
         else begin
            b_w = b_wq.pop_front();
            chk("b_wr_addr", {24'h0, b_addr}, {24'h0, b_w[15:8]});
            chk("b_wr_data", {24'h0, b_wdata}, {24'h0, b_w[7:0]});
         end
      end
      if (b_done) b_dones++;
   end

   task automatic kick(input bit sel);
      if (sel) b_start = 1'b1; else a_start = 1'b1;
      @(negedge clk);
      if (sel) b_start = 1'b0; else a_start = 1'b0;
      chk(sel ? "b_busy_after_accept" : "a_busy_after_accept", sel ? b_busy : a_busy, 1);
   endtask

   task automatic wait_done(input bit sel, input int n0, input int exp, input string tag);
      int n;
      n = n0;
      while (!(sel ? b_done : a_done) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, exp);
   endtask

   task automatic chk_zero_a(input string pfx);
      chk({pfx, "_addr"}, {24'h0, a_addr}, 0);
      chk({pfx, "_wdata"}, {24'h0, a_wdata}, 0);
      chk({pfx, "_wen"}, a_wen, 0);
      chk({pfx, "_fp_a"}, a_fp_a, 0);
      chk({pfx, "_fp_b"}, a_fp_b, 0);
      chk({pfx, "_fp_start"}, a_fp_start, 0);
      chk({pfx, "_busy"}, a_busy, 0);
      chk({pfx, "_done"}, a_done, 0);
      chk({pfx, "_err"}, a_err, 0);
   endtask

   int d0, dn;

   initial begin
      for (int i = 0; i < 256; i++) begin ram_a[i] = 8'h00; ram_b[i] = 8'h00; end
      repeat (3) @(negedge clk);
      chk_zero_a("rst");
      chk("rst_b_busy", b_busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single op, operands wrap FC..FF,00..03; 1.0 + 2.0 = 3.0.
      push_op(1, 8'hFC, 8'h40, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 3, 4);
      kick(1);
      wait_done(1, 1, 18, "b_add_done_cycle");
      chk("b_add_err", b_err, 0);
      @(negedge clk);
      chk("b_busy_after_done", b_busy, 0);

      // fp_done lands on the same cycle the watchdog expires.
      push_op(1, 8'hFC, 8'h40, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 8, 4);
      kick(1);
      wait_done(1, 1, 23, "b_coincident_done_cycle");
      chk("b_coincident_err", b_err, 0);
      @(negedge clk);

      push_op(1, 8'hFC, 8'h40, 32'h3F80_0000, 32'h3F80_0000, 32'h0, QNAN, 0, 4);
      kick(1);
      wait_done(1, 1, 23, "b_timeout_done_cycle");
      chk("b_timeout_err", b_err, 1);
      @(negedge clk);

      // Two ops with latencies 1 and 7.
      push_op(0, 8'h00, 8'h40, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1, 4);
      push_op(0, 8'h08, 8'h44, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 7, 4);
      kick(0);
      wait_done(0, 1, 37, "a_two_op_done_cycle");
      chk("a_two_op_err", a_err, 0);
      @(negedge clk);

      // FP unit never answers: both ops write qNaN.
      push_op(0, 8'h00, 8'h40, 32'h3F80_0000, 32'h4000_0000, 32'h0, QNAN, 0, 4);
      push_op(0, 8'h08, 8'h44, 32'h4020_0000, 32'h3F00_0000, 32'h0, QNAN, 0, 4);
      kick(0);
      wait_done(0, 1, 157, "a_timeout_done_cycle");
      chk("a_timeout_err", a_err, 1);
      repeat (5) @(negedge clk);
      chk("a_err_sticky", a_err, 1);

      // start pulsed during READ and WRITE must be ignored.
      push_op(0, 8'h00, 8'h40, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2, 4);
      push_op(0, 8'h08, 8'h44, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 2, 4);
      d0 = a_dones;
      dn = 0;
      kick(0);
      chk("a_err_cleared", a_err, 0);
      for (int n = 2; n <= 40; n++) begin
         @(negedge clk);
         a_start = (n == 3 || n == 13);
         if (a_done) dn = n;
      end
      a_start = 1'b0;
      chk("a_pulse_done_cycle", dn, 33);
      chk("a_pulse_done_count", a_dones - d0, 1);

      // start held across DONE: second job one idle cycle later.
      for (int j = 0; j < 2; j++) begin
         push_op(0, 8'h00, 8'h40, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1, 4);
         push_op(0, 8'h08, 8'h44, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 1, 4);
      end
      a_start = 1'b1;
      wait_done(0, 0, 31, "a_held_done1_cycle");
      @(negedge clk);
      chk("a_held_idle_gap", a_busy, 0);
      @(negedge clk);
      chk("a_held_restart", a_busy, 1);
      a_start = 1'b0;
      wait_done(0, 1, 31, "a_held_done2_cycle");
      @(negedge clk);

      // Reset during the second byte of the second op's write-back.
      push_op(0, 8'h00, 8'h40, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 2, 4);
      push_op(0, 8'h08, 8'h44, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 2, 1);
      kick(0);
      repeat (29) @(posedge clk);
      #1;
      chk("a_pre_reset_wen", a_wen, 1);
      rst_n = 1'b0;
      #1;
      chk_zero_a("midjob_rst");
      d0 = a_dones;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("a_no_done_after_rst", a_dones - d0, 0);
      chk("a_wq_after_rst", a_wq.size(), 0);
      chk("a_opq_after_rst", a_opq.size(), 0);

      push_op(0, 8'h00, 8'h40, 32'h4020_0000, 32'h3F00_0000, 32'h4040_0000, 32'h4040_0000, 1, 4);
      push_op(0, 8'h08, 8'h44, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1, 4);
      kick(0);
      wait_done(0, 1, 31, "a_clean_done_cycle");
      chk("a_clean_err", a_err, 0);
      repeat (3) @(negedge clk);

      chk("a_wq_empty", a_wq.size(), 0);
      chk("a_opq_empty", a_opq.size(), 0);
      chk("b_wq_empty", b_wq.size(), 0);
      chk("b_opq_empty", b_opq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
